// File: rtl/breath_pwm_multi.sv
// Multi-channel breathing PWM: arithmetic triangle duty, per-channel phase, prescaler, 4 modes.
// Outputs registered one cycle after the PWM count; `BREATH_GAMMA_EN squares the duty for ~gamma 2.
module breath_pwm_multi #(
  parameter int PWM_W      = 6,
  parameter int IDX_W      = 6,
  parameter int NUM_CH     = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  period_tick
);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_SOLID   = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;

  localparam int TRI_W = IDX_W - 1;
  localparam int REP   = PWM_W / TRI_W + 1;
  localparam int STEP  = (1 << IDX_W) / NUM_CH;

  logic [PRESCALE_W-1:0]         presc_q, presc_d;
  logic [PWM_W-1:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]              base_q, base_d;
  logic [1:0]                    mode_q, mode_d;
  logic [NUM_CH-1:0][PWM_W-1:0]  duty_q, duty_d;
  logic [NUM_CH-1:0]             blink_q, blink_d;
  logic [NUM_CH-1:0]             pwm_q, pwm_d;
  logic                          ptick_q;

  logic                          tick;
  logic                          period_end;
  logic [NUM_CH-1:0][PWM_W-1:0]  duty_c;
  logic [NUM_CH-1:0]             msb_c;

  assign tick       = enable && (presc_q >= prescale);
  assign period_end = tick && (cnt_q == {PWM_W{1'b1}});

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [IDX_W-1:0]       idx;
    logic [TRI_W-1:0]       tri_v;
    logic [REP*TRI_W-1:0]   rep;
    logic [PWM_W-1:0]       lin;

    assign idx   = base_q + IDX_W'(c * STEP);
    assign tri_v = idx[IDX_W-1] ? ~idx[TRI_W-1:0] : idx[TRI_W-1:0];
    // Repeating the triangle bits stretches it to full scale: 0 -> 0, all-ones -> all-ones.
    assign rep   = {REP{tri_v}};
    assign lin   = PWM_W'(rep >> (REP*TRI_W - PWM_W));
    assign msb_c[c] = idx[IDX_W-1];
`ifdef BREATH_GAMMA_EN
    logic [2*PWM_W-1:0] sq;
    assign sq        = {{PWM_W{1'b0}}, lin} * {{PWM_W{1'b0}}, lin};
    assign duty_c[c] = PWM_W'(sq >> PWM_W);
`else
    assign duty_c[c] = lin;
`endif
  end

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    mode_d  = mode_q;
    duty_d  = duty_q;
    blink_d = blink_q;
    if (enable) presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);
    if (tick)   cnt_d   = cnt_q + PWM_W'(1);
    // Latching only here keeps duty/mode changes aligned to period boundaries.
    if (period_end) begin
      base_d  = base_q + IDX_W'(1);
      mode_d  = mode;
      duty_d  = duty_c;
      blink_d = msb_c;
    end
  end

  always_comb begin
    pwm_d = '0;
    if (enable) begin
      case (mode_q)
        MODE_OFF:     pwm_d = '0;
        MODE_SOLID:   pwm_d = '1;
        MODE_BREATHE: for (int c = 0; c < NUM_CH; c++) pwm_d[c] = (cnt_q < duty_q[c]);
        MODE_BLINK:   pwm_d = blink_q;
        default:      pwm_d = '0;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      mode_q  <= MODE_OFF;
      duty_q  <= '0;
      blink_q <= '0;
      pwm_q   <= '0;
      ptick_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      blink_q <= blink_d;
      pwm_q   <= pwm_d;
      ptick_q <= period_end;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = ptick_q;

endmodule

// File: doc/breath_pwm_multi.md
Name: breath_pwm_multi

Overview:
Multi-channel breathing-LED PWM generator: a parametrised successor to the single-channel 6-bit fixed-LUT breathing block.
- Triangle-wave duty computed arithmetically, not from a LUT.
- Per-channel phase offset, programmable prescaler, four output modes.
- Duty and mode updates are glitch-free at PWM period boundaries.
- Sits between the board switch/config logic and the LED pins.

Parameters:
PWM_W, 6, PWM counter/duty width; PWM period = 2^PWM_W ticks
IDX_W, 6, breath index width (≥2); breath cycle = 2^IDX_W PWM periods
NUM_CH, 4, number of output channels (≥1)
PRESCALE_W, 8, prescaler compare width

Ports:
sysclk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
enable  in  1  run enable; low freezes counters and forces outputs low
mode  in  2  00 OFF, 01 SOLID, 10 BREATHE, 11 BLINK
prescale  in  PRESCALE_W  tick every prescale+1 sysclk cycles
pwm_out  out  NUM_CH  registered PWM outputs
period_tick  out  1  one-cycle pulse at each PWM period end

Behaviour:
- Reset (async assert, sync release):
  - presc_cnt, pwm count and base_idx = 0.
  - Latched mode = OFF; all latched duties = 0.
  - pwm_out = 0; period_tick = 0.
- Prescaler: tick when enable && presc_cnt >= prescale; presc_cnt then returns to 0, else increments.
  - prescale = 0 gives a tick every cycle.
  - If prescale is lowered below presc_cnt, the ">=" compare forces a tick on the next cycle.
- PWM count advances by 1 on each tick, wrapping 2^PWM_W-1 → 0.
- Period end = tick with count == all-ones. On that cycle:
  - base_idx increments (wraps mod 2^IDX_W).
  - period_tick = 1 on the next sysclk edge, for exactly one cycle.
  - mode and every channel duty are latched from the current combinational values.
  - Inputs changed mid-period therefore take effect when count next reads 0.
- Channel index: ch_idx[c] = (base_idx + c*(2^IDX_W/NUM_CH)) mod 2^IDX_W, integer division.
- Triangle value (IDX_W-1 bits): tri = ch_idx[IDX_W-2:0] if ch_idx MSB = 0, else its bitwise inverse.
- Linear duty (PWM_W bits): top PWM_W bits of tri concatenated with itself repeatedly. Consequences:
  - tri = 0 → duty 0.
  - tri all-ones → duty all-ones.
- Output, registered (1 sysclk after count changes), per latched mode:
  - OFF: pwm_out = 0.
  - SOLID: pwm_out = all ones.
  - BREATHE: pwm_out[c] = (count < duty_l[c]). Duty 0 is never high; all-ones duty is high for 2^PWM_W-1 of 2^PWM_W ticks.
  - BLINK: pwm_out[c] = ch_idx[c] MSB (from latched index).
- enable low:
  - presc_cnt, count and base_idx hold.
  - pwm_out = 0 and period_tick = 0 from the next edge.
  - On re-enable, resume from held state; no re-latch until the next period end.
- Simultaneous period end and mode change: the new mode is latched on that same cycle.
- Reset mid-operation returns everything to reset values immediately; the first period after release uses mode OFF.

Optional Feature:
Macro BREATH_GAMMA_EN.
- Defined: duty = upper PWM_W bits of (linear duty × linear duty), giving a perceptual gamma ≈ 2. Computed combinationally before the latch, so latency is unchanged.
- Undefined: linear duty as above.

Test Plan:
All scenarios use PWM_W=4, IDX_W=4, NUM_CH=2.
- Reset, mode=10, prescale=0, enable=1 → period_tick every 16 cycles; ch0 duty 0 (idx0), ch1 idx 8 → tri 7 → duty 15, high 15 of 16 cycles.
- prescale=3 → count steps every 4 cycles; period_tick every 64 cycles; lowering prescale to 0 while presc_cnt=2 → tick on the next cycle.
- BREATHE with base_idx=3 → tri 3 → duty 6 → ch0 high for 6 of 16 ticks; with BREATH_GAMMA_EN, duty 15 → 225>>4 = 14.
- Switch mode 10→01 at count=5 → outputs are unchanged until count returns to 0, then pwm_out = 2'b11.
- enable low for 20 cycles at count=9 → pwm_out=0, count holds at 9, resumes at 10 after re-enable; reset asserted mid-period → pwm_out=0 asynchronously, and after release outputs stay 0 until the first period end.
